// File: rtl/fasm_fifo_warb.sv
// fasm_fifo_warb: round-robin arbiter sharing one fasm_fifo write port among 2**TW producers.
// A grantee keeps the port for up to BL accepted beats; priority then rotates past it.
module fasm_fifo_warb #(
  parameter int TW = 2,
  parameter int DW = 32,
  parameter int BL = 4,
  localparam int N = 2 ** TW
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ena_i,
  input  logic [N-1:0]    req_i,
  input  logic [N*DW-1:0] dat_i,
  output logic [N-1:0]    ack_o,
  output logic [N-1:0]    gnt_o,
  input  logic            fwok_i,
  output logic            fwre_o,
  output logic [DW-1:0]   fdat_o,
  output logic [TW-1:0]   ftag_o
);

  localparam int CW = (BL > 1) ? $clog2(BL) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BL - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state;
  logic [TW-1:0] r_g;
  logic [TW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_gnt;

  logic          w_accept;
  logic          w_last;
  logic          w_found;
  logic [TW-1:0] w_pick;
  logic [TW-1:0] w_idx;

  // Reset gates the strobe so an in-flight beat is dropped in the reset cycle itself.
  assign w_accept = ena_i & rst_i & (r_state == S_BUSY) & req_i[r_g] & fwok_i;
  assign w_last   = (r_cnt == LAST_BEAT);

  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = r_ptr + TW'(i);
      if (!w_found && req_i[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ack
    assign ack_o[gi] = w_accept & (r_g == TW'(gi));
  end

  assign fwre_o = w_accept;
  assign fdat_o = dat_i[r_g*DW +: DW];
  assign ftag_o = r_g;
  assign gnt_o  = r_gnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_g     <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
    end else if (ena_i) begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_BUSY;
            r_g     <= w_pick;
            r_cnt   <= '0;
            r_gnt   <= N'(1) << w_pick;
          end
        end
        S_BUSY: begin
          if (!req_i[r_g] || (w_accept && w_last)) begin
            r_state <= S_IDLE;
            r_ptr   <= r_g + 1'b1;
            r_gnt   <= '0;
          end else if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fasm_fifo_warb.sv
// Bench for fasm_fifo_warb: producer models feed the arbiter, a scoreboard holds the
// expected (tag, data) write order, and each scenario task checks cycle-level behaviour.
module tb_fasm_fifo_warb;

  localparam int TW = 2;
  localparam int DW = 32;
  localparam int BL = 4;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ena = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] dat = '0;
  logic [N-1:0]    ack_o;
  logic [N-1:0]    gnt_o;
  logic            fwok = 1'b1;
  logic            fwre_o;
  logic [DW-1:0]   fdat_o;
  logic [TW-1:0]   ftag_o;

  fasm_fifo_warb #(.TW(TW), .DW(DW), .BL(BL)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .ena_i (ena),
    .req_i (req),
    .dat_i (dat),
    .ack_o (ack_o),
    .gnt_o (gnt_o),
    .fwok_i(fwok),
    .fwre_o(fwre_o),
    .fdat_o(fdat_o),
    .ftag_o(ftag_o)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          writes  = 0;
  int          rem[N];
  int          seq[N];
  logic [33:0] sb[$];
  logic [N-1:0] last_ack;
  logic [N-1:0] last_gnt;
  logic         last_fwre;
  logic [TW-1:0] last_tag;

  function automatic logic [31:0] word(input int k, input int s);
    return (32'(k) << 24) | 32'(s);
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req[k] = (rem[k] > 0);
      dat[k*DW +: DW] = word(k, seq[k]);
    end
  endtask

  task automatic expect_words(input int k, input int first, input int count);
    for (int s = first; s < first + count; s++) sb.push_back({2'(k), word(k, s)});
  endtask

  // One clock: sample mid-cycle, score any write, then advance producers past acked words.
  task automatic tick();
    logic [33:0]  exp;
    logic [N-1:0] exp_ack;
    @(negedge clk);
    last_ack  = ack_o;
    last_gnt  = gnt_o;
    last_fwre = fwre_o;
    last_tag  = ftag_o;
    if (fwre_o === 1'b1) begin
      writes++;
      $display("[TB] cyc %0d write tag=%0d data=%h", cyc, ftag_o, fdat_o);
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got tag=%0d data=%h, required no write", ftag_o, fdat_o);
      end else begin
        exp = sb.pop_front();
        if ({ftag_o, fdat_o} !== exp)
          begin n_fail++; $display("FAIL sb_word: got %h, required %h", {ftag_o, fdat_o}, exp); end
      end
      exp_ack = 4'b0001 << ftag_o;
      n_tests++;
      if (ack_o !== exp_ack)
        begin n_fail++; $display("FAIL ack_onehot: got %b, required %b", ack_o, exp_ack); end
    end else begin
      n_tests++;
      if (ack_o !== 4'b0000)
        begin n_fail++; $display("FAIL ack_no_write: got %b, required 0000", ack_o); end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++)
      if (last_ack[k] === 1'b1 && rem[k] > 0) begin rem[k]--; seq[k]++; end
    drive();
  endtask

  task automatic check_quiet(input string name, input logic [N-1:0] exp_gnt);
    n_tests++;
    if (last_fwre !== 1'b0 || last_ack !== 4'b0000 || last_gnt !== exp_gnt) begin
      n_fail++;
      $display("FAIL %s: got fwre=%b ack=%b gnt=%b, required fwre=0 ack=0000 gnt=%b",
               name, last_fwre, last_ack, last_gnt, exp_gnt);
    end
  endtask

  task automatic check_sb_empty(input string name);
    n_tests++;
    if (sb.size() != 0)
      begin n_fail++; $display("FAIL %s_sb_empty: got %0d pending, required 0", name, sb.size()); end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin rem[k] = 0; seq[k] = 0; end
    drive();
    for (int i = 0; i < n; i++) begin
      tick();
      check_quiet("reset_quiet", (i == 0) ? last_gnt : 4'b0000);
    end
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin rem[k] = 1; seq[k] = 0; end
    drive();
    expect_words(0, 0, 1);
    tick();
    n_tests++;
    if (last_fwre !== 1'b0 || last_ack !== 4'b0000)
      begin n_fail++; $display("FAIL reset_gated: got fwre=%b ack=%b, required 0/0000", last_fwre, last_ack); end
    tick();
    check_quiet("reset_held", 4'b0000);
    rst_n = 1'b1;
    tick();
    check_quiet("reset_idle", 4'b0000);
    tick();
    n_tests++;
    if (last_gnt !== 4'b0001 || last_fwre !== 1'b1 || last_tag !== 2'd0)
      begin n_fail++; $display("FAIL reset_first_grant: got gnt=%b fwre=%b tag=%0d, required 0001/1/0", last_gnt, last_fwre, last_tag); end
    check_sb_empty("reset");
  endtask

  task automatic test_single();
    int ack_cyc[$];
    int exp_cyc[6] = '{1, 2, 3, 4, 6, 7};
    do_reset(2);
    rem[1] = 6;
    expect_words(1, 0, 6);
    drive();
    for (int c = 0; c < 10; c++) begin
      tick();
      if (last_ack[1] === 1'b1) ack_cyc.push_back(c);
      if (c == 5) check_quiet("single_bubble", 4'b0000);
      if (c == 1 || c == 6) begin
        n_tests++;
        if (last_gnt !== 4'b0010)
          begin n_fail++; $display("FAIL single_gnt c%0d: got %b, required 0010", c, last_gnt); end
      end
    end
    n_tests++;
    if (ack_cyc.size() != 6) begin
      n_fail++; $display("FAIL single_ack_count: got %0d, required 6", ack_cyc.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_tests++;
        if (ack_cyc[i] != exp_cyc[i])
          begin n_fail++; $display("FAIL single_ack_cycle %0d: got %0d, required %0d", i, ack_cyc[i], exp_cyc[i]); end
      end
    end
    check_sb_empty("single");
  endtask

  task automatic test_round_robin();
    do_reset(2);
    for (int k = 0; k < N; k++) rem[k] = 8;
    for (int b = 0; b < 2; b++)
      for (int p = 0; p < N; p++) expect_words(p, b * BL, BL);
    drive();
    for (int c = 0; c <= 40; c++) begin
      tick();
      n_tests++;
      if (last_fwre !== ((c % 5) != 0))
        begin n_fail++; $display("FAIL rr_cadence c%0d: got fwre=%b, required %b", c, last_fwre, (c % 5) != 0); end
    end
    check_sb_empty("rr");
  endtask

  task automatic test_backpressure();
    int w0;
    do_reset(2);
    rem[0] = 4;
    expect_words(0, 0, 4);
    drive();
    w0 = writes;
    tick(); tick(); tick();
    fwok = 1'b0;
    for (int c = 3; c <= 5; c++) begin tick(); check_quiet("bp_stall", 4'b0001); end
    fwok = 1'b1;
    tick(); tick();
    tick();
    check_quiet("bp_end", 4'b0000);
    n_tests++;
    if (writes - w0 != 4)
      begin n_fail++; $display("FAIL bp_beats: got %0d, required 4", writes - w0); end
    check_sb_empty("bp");
  endtask

  task automatic test_back_to_back();
    do_reset(2);
    rem[0] = 1;
    rem[3] = 4;
    expect_words(0, 0, 1);
    expect_words(3, 0, 4);
    expect_words(0, 1, 1);
    expect_words(3, 4, 1);
    drive();
    for (int c = 0; c <= 14; c++) begin
      tick();
      if (c == 2) check_quiet("early_release", 4'b0001);
      if (c == 3) check_quiet("early_idle", 4'b0000);
      if (c == 4 || c == 12) begin
        n_tests++;
        if (last_gnt !== 4'b1000)
          begin n_fail++; $display("FAIL grant3 c%0d: got %b, required 1000", c, last_gnt); end
      end
      if (c == 9) begin
        n_tests++;
        if (last_gnt !== 4'b0001)
          begin n_fail++; $display("FAIL ptr_wrap: got gnt=%b, required 0001", last_gnt); end
      end
      if (c == 7) begin rem[0] = 1; rem[3] = 1; drive(); end
    end
    check_sb_empty("b2b");
  endtask

  task automatic test_enable_reset();
    do_reset(2);
    rem[2] = 8;
    expect_words(2, 0, 5);
    drive();
    tick(); tick(); tick();
    ena = 1'b0;
    for (int c = 3; c <= 4; c++) begin tick(); check_quiet("ena_freeze", 4'b0100); end
    ena = 1'b1;
    tick(); tick();
    tick();
    check_quiet("ena_burst_end", 4'b0000);
    tick();
    rst_n = 1'b0;
    tick();
    check_quiet("rst_gate", 4'b0100);
    tick();
    check_quiet("rst_gnt", 4'b0000);
    n_tests++;
    if (rem[2] != 3)
      begin n_fail++; $display("FAIL rst_unacked: got %0d left, required 3", rem[2]); end
    check_sb_empty("ena_rst");
    do_reset(1);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin rem[k] = 0; seq[k] = 0; end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_enable_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
